// File: rtl/signed_frame_accumulator_pkg.sv
// Shared types and constants for the signed frame accumulator: state encoding,
// default widths and the signed accumulator limit helper.
package signed_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    localparam int DEF_IN_WIDTH    = 16;
    localparam int DEF_ACC_WIDTH   = 24;
    localparam int DEF_COUNT_WIDTH = 8;

    // Returns the most positive (want_max=1) or most negative (want_max=0)
    // signed value of a width-bit word, as a zero-padded 64-bit pattern.
    function automatic logic [63:0] acc_limit(input int width, input logic want_max);
        logic [63:0] msb_only;
        msb_only = 64'd1 << (width - 1);
        if (want_max) begin
            acc_limit = msb_only - 64'd1;
        end else begin
            acc_limit = msb_only;
        end
    endfunction

endpackage

// File: rtl/signed_frame_accumulator_acc_sat_add.sv
// Combinational signed add with overflow detect. With SIGNED_ACC_SATURATE_EN
// defined the sum clamps to the signed limits on overflow, otherwise it wraps.
module acc_sat_add
    import signed_acc_pkg::*;
#(
    parameter int AccWidth = DEF_ACC_WIDTH
) (
    input  logic [AccWidth-1:0] acc_in,
    input  logic [AccWidth-1:0] operand,
    output logic [AccWidth-1:0] sum,
    output logic                ovf
);

`ifdef SIGNED_ACC_SATURATE_EN
    localparam logic [AccWidth-1:0] ACC_MAX = AccWidth'(acc_limit(AccWidth, 1'b1));
    localparam logic [AccWidth-1:0] ACC_MIN = AccWidth'(acc_limit(AccWidth, 1'b0));
`endif

    logic [AccWidth-1:0] raw_s;

    // Two's-complement add; overflow when like-signed operands give an opposite-signed sum.
    always_comb begin
        raw_s = acc_in + operand;
        ovf   = (acc_in[AccWidth-1] == operand[AccWidth-1]) &&
                (raw_s[AccWidth-1] != acc_in[AccWidth-1]);
`ifdef SIGNED_ACC_SATURATE_EN
        if (ovf) begin
            sum = operand[AccWidth-1] ? ACC_MIN : ACC_MAX;
        end else begin
            sum = raw_s;
        end
`else
        sum = raw_s;
`endif
    end

endmodule

// File: rtl/signed_frame_accumulator.sv
// Sums frame_len signed samples per frame and holds the result on a valid/ready
// output. Optional clamping arithmetic: define SIGNED_ACC_SATURATE_EN.
module signed_frame_accumulator
    import signed_acc_pkg::*;
#(
    parameter int InWidth    = DEF_IN_WIDTH,
    parameter int AccWidth   = DEF_ACC_WIDTH,
    parameter int CountWidth = DEF_COUNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [CountWidth-1:0] frame_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [InWidth-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AccWidth-1:0]   out_data,
    output logic [CountWidth-1:0] out_count,
    output logic                  overflow
);

    generate
        if (AccWidth < InWidth) begin : g_width_check
            $error("signed_frame_accumulator: AccWidth must be >= InWidth");
        end
    endgenerate

    acc_state_e            state_q, state_d;
    logic [AccWidth-1:0]   acc_q, acc_d;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic [CountWidth-1:0] len_q, len_d;
    logic                  sticky_q, sticky_d;
    logic [AccWidth-1:0]   out_data_q, out_data_d;
    logic [CountWidth-1:0] out_count_q, out_count_d;
    logic                  overflow_q, overflow_d;

    logic [AccWidth-1:0]   operand_s;
    logic [AccWidth-1:0]   sum_s;
    logic                  ovf_s;
    logic [CountWidth-1:0] eff_len_s;
    logic [CountWidth-1:0] cnt_inc_s;
    logic                  in_hs_s;
    logic                  out_hs_s;

    assign operand_s = AccWidth'($signed(in_data));

    acc_sat_add #(
        .AccWidth (AccWidth)
    ) u_acc_sat_add (
        .acc_in  (acc_q),
        .operand (operand_s),
        .sum     (sum_s),
        .ovf     (ovf_s)
    );

    // Next-state and frame bookkeeping; clear overrides any handshake this cycle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sticky_d    = sticky_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        overflow_d  = overflow_q;

        in_hs_s   = in_valid && (state_q == ACCUM);
        out_hs_s  = out_ready && (state_q == HOLD);
        // A zero-length request still closes the frame after one sample.
        eff_len_s = (cnt_q == '0) ? ((frame_len == '0) ? CountWidth'(1) : frame_len) : len_q;
        cnt_inc_s = cnt_q + CountWidth'(1);

        if (clear) begin
            state_d    = ACCUM;
            acc_d      = '0;
            cnt_d      = '0;
            sticky_d   = 1'b0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_hs_s) begin
                        len_d = eff_len_s;
                        if (cnt_inc_s == eff_len_s) begin
                            out_data_d  = sum_s;
                            out_count_d = eff_len_s;
                            overflow_d  = sticky_q | ovf_s;
                            state_d     = HOLD;
                            acc_d       = '0;
                            cnt_d       = '0;
                            sticky_d    = 1'b0;
                        end else begin
                            acc_d    = sum_s;
                            cnt_d    = cnt_inc_s;
                            sticky_d = sticky_q | ovf_s;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    if (out_hs_s) begin
                        state_d = ACCUM;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            sticky_q    <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sticky_q    <= sticky_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            overflow_q  <= overflow_d;
        end
    end

    // in_ready drops while rst is asserted so nothing is taken in the reset cycle.
    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Scoreboard bench: a 24-bit and a 16-bit accumulator share one stimulus stream;
// a frame-level arithmetic model predicts each result.
module tb_signed_frame_accumulator;

    localparam int IW = 16;
    localparam int CW = 8;
`ifdef SIGNED_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint data;
        int     count;
        bit     ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, clear, in_valid, out_ready;
    logic [CW-1:0] frame_len;
    logic [IW-1:0] in_data;

    logic          in_ready_a, out_valid_a, overflow_a;
    logic [23:0]   out_data_a;
    logic [CW-1:0] out_count_a;
    logic          in_ready_b, out_valid_b, overflow_b;
    logic [15:0]   out_data_b;
    logic [CW-1:0] out_count_b;

    exp_t    q_a[$];
    exp_t    q_b[$];
    shortint frame_m[$];
    int      len_m;
    bit      hold_m, out_zero_m, ovf_zero_m;
    bit      chk_en, done, rnd_rdy;
    int      timeouts;
    int      n_checks, n_fail;

    signed_frame_accumulator dut_a (
        .clk(clk), .rst(rst), .clear(clear), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_count(out_count_a), .overflow(overflow_a)
    );

    signed_frame_accumulator #(.InWidth(16), .AccWidth(16), .CountWidth(8)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_count(out_count_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    // Expected frame sum for a w-bit accumulator over the collected samples.
    function automatic exp_t model_frame(input int w, input int cnt);
        exp_t   e;
        longint mx, mn, acc, s;
        mx    = (longint'(1) <<< (w - 1)) - 1;
        mn    = -mx - 1;
        acc   = 0;
        e.ovf = 1'b0;
        foreach (frame_m[i]) begin
            s = acc + longint'(frame_m[i]);
            if (s > mx || s < mn) begin
                e.ovf = 1'b1;
                if (SAT) s = (s > mx) ? mx : mn;
                else     s = (s > mx) ? s - (mx - mn + 1) : s + (mx - mn + 1);
            end
            acc = s;
        end
        e.data  = acc;
        e.count = cnt;
        return e;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks frames from the stimulus at each clock edge.
    always @(posedge clk) begin : model
        int eff;
        if (rst || clear) begin
            hold_m <= 1'b0;
            frame_m.delete();
            q_a.delete();
            q_b.delete();
            if (rst) out_zero_m <= 1'b1;
            ovf_zero_m <= 1'b1;
        end else if (hold_m) begin
            if (out_ready) hold_m <= 1'b0;
        end else if (in_valid) begin
            eff = (frame_m.size() == 0) ? ((frame_len == 0) ? 1 : int'(frame_len)) : len_m;
            len_m <= eff;
            frame_m.push_back(shortint'(in_data));
            if (frame_m.size() == eff) begin
                q_a.push_back(model_frame(24, eff));
                q_b.push_back(model_frame(16, eff));
                frame_m.delete();
                hold_m     <= 1'b1;
                out_zero_m <= 1'b0;
                ovf_zero_m <= 1'b0;
            end
        end
    end

    // Monitor: flow-control checks every cycle, result compare on each accept.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (chk_en) begin
            chk("in_ready_a", in_ready_a, !hold_m && !rst);
            chk("in_ready_b", in_ready_b, !hold_m && !rst);
            chk("out_valid_a", out_valid_a, hold_m);
            chk("out_valid_b", out_valid_b, hold_m);
            if (out_zero_m) begin
                chk("rst_out_data_a", out_data_a, 0);
                chk("rst_out_count_a", out_count_a, 0);
                chk("rst_out_data_b", out_data_b, 0);
                chk("rst_out_count_b", out_count_b, 0);
            end
            if (ovf_zero_m && !hold_m) begin
                chk("idle_overflow_a", overflow_a, 0);
                chk("idle_overflow_b", overflow_b, 0);
            end
            if (hold_m && out_ready && !clear && !rst) begin
                if (q_a.size() == 0 || q_b.size() == 0) begin
                    chk("scoreboard_has_entry", 0, 1);
                end else begin
                    e = q_a.pop_front();
                    chk("out_data_a", $signed(out_data_a), e.data);
                    chk("out_count_a", out_count_a, e.count);
                    chk("overflow_a", overflow_a, e.ovf);
                    e = q_b.pop_front();
                    chk("out_data_b", $signed(out_data_b), e.data);
                    chk("out_count_b", out_count_b, e.count);
                    chk("overflow_b", overflow_b, e.ovf);
                end
            end
        end
        if (done) begin
            chk("queue_a_drained", q_a.size(), 0);
            chk("queue_b_drained", q_b.size(), 0);
            chk("handshake_timeouts", timeouts, 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic send(input logic [15:0] d);
        bit took;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        took     = 1'b0;
        n        = 0;
        while (!took && n < 1000) begin
            @(negedge clk);
            took = in_ready_a && !clear && !rst;
            @(posedge clk);
            #1;
            n++;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!took) timeouts++;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [15:0] d;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; frame_len = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(2);

        // basic frame, expected sum -16
        frame_len = 8'd4;
        send(16'h007F); send(16'hFF80); send(16'h0001); send(16'hFFF0);
        cycles(2);

        // backpressure
        out_ready = 1'b0;
        frame_len = 8'd2;
        send(16'd5); send(16'hFFFD);
        cycles(5);
        out_ready = 1'b1;
        cycles(2);

        // overflow in the 16-bit instance only
        send(16'h7FFF); send(16'h0001);
        cycles(2);

        // zero frame length behaves as one
        frame_len = 8'd0;
        send(16'hFFF9);
        cycles(2);

        // clear drops a coincident sample
        frame_len = 8'd3;
        send(16'd10); send(16'd20);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'd30;
        cycles(1);
        clear = 1'b0; in_valid = 1'b0;
        send(16'd1); send(16'd2); send(16'd3);
        cycles(2);

        // reset while a result is held
        out_ready = 1'b0;
        frame_len = 8'd1;
        send(16'd100);
        cycles(2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(1);
        out_ready = 1'b1;
        send(16'd9);
        cycles(2);

        // randomized frames, gaps, backpressure, clears and mid-frame length changes
        rnd_rdy = 1'b1;
        for (int f = 0; f < 150; f++) begin
            frame_len = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
            if ($urandom_range(0, 29) == 0) begin
                clear    = 1'b1;
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 16'($urandom);
                cycles(1);
                clear    = 1'b0;
                in_valid = 1'b0;
            end
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d = {{8{d[7]}}, d[7:0]};
            send(d);
        end
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        clear     = 1'b1;
        cycles(1);
        clear     = 1'b0;

        // longest frame at full positive scale
        frame_len = 8'd255;
        for (int i = 0; i < 255; i++) send(16'h7FFF);
        cycles(4);
        done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
